// File: rtl/mm_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// mm_job_scheduler_pkg : shared state encodings and job-word layout
// Rev 1.0
// ============================================================================
package mm_job_scheduler_pkg;

  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    SCH_IDLE    = 2'b00,
    SCH_ISSUE   = 2'b01,
    SCH_RELEASE = 2'b10
  } sch_state_t;

  // Packed job word is {base_p, base_a, base_b, n, k, m}; offsets are in field units
  localparam int JOB_FIELDS = 6;
  localparam int OFF_M      = 0;
  localparam int OFF_K      = 1;
  localparam int OFF_N      = 2;
  localparam int OFF_BASE_B = 3;
  localparam int OFF_BASE_A = 4;
  localparam int OFF_BASE_P = 5;

endpackage
`default_nettype wire

// File: rtl/mm_job_scheduler_job_fifo.sv
`default_nettype none
// ============================================================================
// mm_job_scheduler_job_fifo : single-clock first-word-fall-through job queue
// Rev 1.0
// ============================================================================
module mm_job_scheduler_job_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB separates the full case from the empty case
  assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign data_o    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/mm_job_scheduler.sv
`default_nettype none
// ============================================================================
// mm_job_scheduler : queues matmul jobs and sequences them into the controller
// Rev 1.0
// ============================================================================
module mm_job_scheduler
  import mm_job_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [ADDR_WIDTH-1:0] job_m_i,
  input  logic [ADDR_WIDTH-1:0] job_k_i,
  input  logic [ADDR_WIDTH-1:0] job_n_i,
  input  logic [ADDR_WIDTH-1:0] job_base_a_i,
  input  logic [ADDR_WIDTH-1:0] job_base_b_i,
  input  logic [ADDR_WIDTH-1:0] job_base_p_i,
  output logic                  ctrl_start_o,
  input  logic                  ctrl_valid_i,
  output logic [ADDR_WIDTH-1:0] ctrl_m_o,
  output logic [ADDR_WIDTH-1:0] ctrl_k_o,
  output logic [ADDR_WIDTH-1:0] ctrl_n_o,
  output logic [ADDR_WIDTH-1:0] ctrl_base_a_o,
  output logic [ADDR_WIDTH-1:0] ctrl_base_b_o,
  output logic [ADDR_WIDTH-1:0] ctrl_base_p_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            jobs_done_o,
  output logic                  rejected_o,
  output logic                  timeout_o,
  input  logic                  clear_i
);

  localparam int JW  = JOB_FIELDS * ADDR_WIDTH;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] C_TIMEOUT = WDW'(TIMEOUT_CYCLES);

  sch_state_t            r_state;
  logic                  r_start;
  logic                  r_done;
  logic                  r_job_pending;
  logic [WDW-1:0]        r_wdog;
  logic [7:0]            r_jobs_done;
  logic                  r_rejected;
  logic                  r_timeout;
  logic [ADDR_WIDTH-1:0] r_m, r_k, r_n, r_base_a, r_base_b, r_base_p;

  logic [JW-1:0] w_job_in;
  logic [JW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_zero_dim;
  logic          w_offer;
  logic          w_push;
  logic          w_reject;
  logic          w_pop;
  logic          w_job_complete;
  logic          w_wdog_hit;

  assign w_job_in   = {job_base_p_i, job_base_a_i, job_base_b_i, job_n_i, job_k_i, job_m_i};
  assign w_zero_dim = (job_m_i == '0) || (job_k_i == '0) || (job_n_i == '0);
  assign w_offer    = job_valid_i && !w_full;
  assign w_push     = w_offer && !w_zero_dim;
  assign w_reject   = w_offer && w_zero_dim;
  // Issue decision uses a one-cycle-late view of occupancy, so a fresh push starts on the second edge
  assign w_pop          = (r_state == SCH_IDLE) && r_job_pending;
  assign w_job_complete = (r_state == SCH_RELEASE) && !ctrl_valid_i;
  assign w_wdog_hit     = (r_state == SCH_ISSUE) && !ctrl_valid_i && (r_wdog == C_TIMEOUT - 1'b1);

  mm_job_scheduler_job_fifo #(
    .WIDTH (JW),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_job_in),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= SCH_IDLE;
      r_start       <= 1'b0;
      r_done        <= 1'b0;
      r_job_pending <= 1'b0;
      r_wdog        <= '0;
      r_jobs_done   <= 8'd0;
      r_rejected    <= 1'b0;
      r_timeout     <= 1'b0;
      r_m           <= '0;
      r_k           <= '0;
      r_n           <= '0;
      r_base_a      <= '0;
      r_base_b      <= '0;
      r_base_p      <= '0;
    end else begin
      r_job_pending <= !w_empty;
      r_done        <= 1'b0;
      case (r_state)
        SCH_IDLE: begin
          if (r_job_pending) begin
            r_state  <= SCH_ISSUE;
            r_start  <= 1'b1;
            r_wdog   <= '0;
            r_m      <= w_head[OFF_M*ADDR_WIDTH +: ADDR_WIDTH];
            r_k      <= w_head[OFF_K*ADDR_WIDTH +: ADDR_WIDTH];
            r_n      <= w_head[OFF_N*ADDR_WIDTH +: ADDR_WIDTH];
            r_base_a <= w_head[OFF_BASE_A*ADDR_WIDTH +: ADDR_WIDTH];
            r_base_b <= w_head[OFF_BASE_B*ADDR_WIDTH +: ADDR_WIDTH];
            r_base_p <= w_head[OFF_BASE_P*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        SCH_ISSUE: begin
          if (ctrl_valid_i) begin
            r_state <= SCH_RELEASE;
            r_start <= 1'b0;
          end else if (r_wdog != C_TIMEOUT) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        SCH_RELEASE: begin
          if (!ctrl_valid_i) begin
            r_state <= SCH_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= SCH_IDLE;
          r_start <= 1'b0;
        end
      endcase

      if (clear_i) begin
        r_jobs_done <= 8'd0;
        r_rejected  <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        if (w_job_complete) r_jobs_done <= r_jobs_done + 8'd1;
        if (w_reject)       r_rejected  <= 1'b1;
        if (w_wdog_hit)     r_timeout   <= 1'b1;
      end
    end
  end

  assign job_ready_o   = !w_full;
  assign busy_o        = (r_state != SCH_IDLE) || !w_empty;
  assign ctrl_start_o  = r_start;
  assign done_o        = r_done;
  assign jobs_done_o   = r_jobs_done;
  assign rejected_o    = r_rejected;
  assign timeout_o     = r_timeout;
  assign ctrl_m_o      = r_m;
  assign ctrl_k_o      = r_k;
  assign ctrl_n_o      = r_n;
  assign ctrl_base_a_o = r_base_a;
  assign ctrl_base_b_o = r_base_b;
  assign ctrl_base_p_o = r_base_p;

endmodule
`default_nettype wire

// File: tb/tb_mm_job_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mm_job_scheduler : directed self-checking bench for mm_job_scheduler
// Rev 1.0
// ============================================================================
module tb_mm_job_scheduler;

  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          job_valid_i = 1'b0;
  logic          ctrl_valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [AW-1:0] job_m_i = '0, job_k_i = '0, job_n_i = '0;
  logic [AW-1:0] job_base_a_i = '0, job_base_b_i = '0, job_base_p_i = '0;
  logic          job_ready_o, ctrl_start_o, busy_o, done_o, rejected_o, timeout_o;
  logic [AW-1:0] ctrl_m_o, ctrl_k_o, ctrl_n_o, ctrl_base_a_o, ctrl_base_b_o, ctrl_base_p_o;
  logic [7:0]    jobs_done_o;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  mm_job_scheduler #(
    .ADDR_WIDTH     (AW),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_m_i       (job_m_i),
    .job_k_i       (job_k_i),
    .job_n_i       (job_n_i),
    .job_base_a_i  (job_base_a_i),
    .job_base_b_i  (job_base_b_i),
    .job_base_p_i  (job_base_p_i),
    .ctrl_start_o  (ctrl_start_o),
    .ctrl_valid_i  (ctrl_valid_i),
    .ctrl_m_o      (ctrl_m_o),
    .ctrl_k_o      (ctrl_k_o),
    .ctrl_n_o      (ctrl_n_o),
    .ctrl_base_a_o (ctrl_base_a_o),
    .ctrl_base_b_o (ctrl_base_b_o),
    .ctrl_base_p_o (ctrl_base_p_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .jobs_done_o   (jobs_done_o),
    .rejected_o    (rejected_o),
    .timeout_o     (timeout_o),
    .clear_i       (clear_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o) done_pulses++;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish within time limit");
    $fatal(1, "bench time limit expired");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_job(input logic [AW-1:0] m, k, n, a, b, p);
    job_m_i = m; job_k_i = k; job_n_i = n;
    job_base_a_i = a; job_base_b_i = b; job_base_p_i = p;
  endtask

  task automatic push_job(input logic [AW-1:0] m, k, n, a, b, p);
    set_job(m, k, n, a, b, p);
    job_valid_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (ctrl_start_o) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic finish_job;
    ctrl_valid_i = 1'b1;
    tick();
    ctrl_valid_i = 1'b0;
    tick();
  endtask

  function automatic logic [6*AW-1:0] ctrl_word();
    return {ctrl_base_p_o, ctrl_base_a_o, ctrl_base_b_o, ctrl_n_o, ctrl_k_o, ctrl_m_o};
  endfunction

  task automatic test_reset;
    tick(); tick();
    checks++; if (ctrl_start_o !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", ctrl_start_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++; if (job_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", job_ready_o); end
    checks++; if ({done_o, rejected_o, timeout_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done_o, rejected_o, timeout_o}); end
    checks++; if (jobs_done_o !== 8'd0) begin failures++; $display("FAIL reset_jobs_done got=%0d exp=0", jobs_done_o); end
    checks++; if (ctrl_word() !== '0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_word()); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single;
    int d0;
    logic [6*AW-1:0] exp_w;
    d0 = done_pulses;
    exp_w = {16'h0200, 16'h0000, 16'h0100, 16'd10, 16'd16, 16'd10};
    push_job(16'd10, 16'd16, 16'd10, 16'h0000, 16'h0100, 16'h0200);
    checks++; if (ctrl_start_o !== 1'b0) begin failures++; $display("FAIL single_lat_e0 got=%0b exp=0", ctrl_start_o); end
    tick();
    checks++; if (ctrl_start_o !== 1'b0) begin failures++; $display("FAIL single_lat_e1 got=%0b exp=0", ctrl_start_o); end
    tick();
    checks++; if (ctrl_start_o !== 1'b1) begin failures++; $display("FAIL single_lat_e2 got=%0b exp=1", ctrl_start_o); end
    checks++; if (ctrl_word() !== exp_w) begin failures++; $display("FAIL single_ctrl got=%h exp=%h", ctrl_word(), exp_w); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", busy_o); end
    ctrl_valid_i = 1'b1;
    tick();
    checks++; if (ctrl_start_o !== 1'b0) begin failures++; $display("FAIL single_start_drop got=%0b exp=0", ctrl_start_o); end
    repeat (4) tick();
    ctrl_valid_i = 1'b0;
    tick();
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL single_done got=%0b exp=1", done_o); end
    checks++; if (jobs_done_o !== 8'd1) begin failures++; $display("FAIL single_jobs_done got=%0d exp=1", jobs_done_o); end
    checks++; if (ctrl_word() !== exp_w) begin failures++; $display("FAIL single_ctrl_hold got=%h exp=%h", ctrl_word(), exp_w); end
    tick();
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL single_done_low got=%0b exp=0", done_o); end
    checks++; if (done_pulses - d0 !== 1) begin failures++; $display("FAIL single_pulse_count got=%0d exp=1", done_pulses - d0); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6*AW-1:0] exp_w;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    push_job(16'd1, 16'd2, 16'd3, 16'h10, 16'h11, 16'h12);
    tick(); tick();
    checks++; if (ctrl_start_o !== 1'b1) begin failures++; $display("FAIL b2b_first_issue got=%0b exp=1", ctrl_start_o); end
    for (int j = 2; j <= 5; j++) begin
      push_job(AW'(j), AW'(j + 1), AW'(j + 2), AW'(16 * j), AW'(16 * j + 1), AW'(16 * j + 2));
      if (j == 4) begin
        checks++; if (job_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_3q got=%0b exp=1", job_ready_o); end
      end
    end
    checks++; if (job_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%0b exp=0", job_ready_o); end
    push_job(16'd99, 16'd99, 16'd99, 16'h99, 16'h99, 16'h99);
    checks++; if (job_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_extra got=%0b exp=0", job_ready_o); end
    for (int j = 1; j <= 5; j++) begin
      exp_w = {AW'(16 * j + 2), AW'(16 * j), AW'(16 * j + 1), AW'(j + 2), AW'(j + 1), AW'(j)};
      wait_start(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_start_timeout job=%0d got=0 exp=1", j); end
      checks++; if (ctrl_word() !== exp_w) begin failures++; $display("FAIL b2b_order job=%0d got=%h exp=%h", j, ctrl_word(), exp_w); end
      ctrl_valid_i = 1'b1; tick();
      ctrl_valid_i = 1'b0; tick();
      checks++; if (ctrl_start_o !== 1'b0) begin failures++; $display("FAIL b2b_gap job=%0d got=%0b exp=0", j, ctrl_start_o); end
    end
    checks++; if (jobs_done_o !== 8'd5) begin failures++; $display("FAIL b2b_jobs_done got=%0d exp=5", jobs_done_o); end
    repeat (6) tick();
    checks++; if ({ctrl_start_o, busy_o} !== 2'b00) begin failures++; $display("FAIL b2b_drained got=%b exp=00", {ctrl_start_o, busy_o}); end
  endtask

  task automatic test_reject;
    push_job(16'd5, 16'd0, 16'd5, 16'h1, 16'h2, 16'h3);
    checks++; if (rejected_o !== 1'b1) begin failures++; $display("FAIL rej_k0 got=%0b exp=1", rejected_o); end
    checks++; if (job_ready_o !== 1'b1) begin failures++; $display("FAIL rej_ready got=%0b exp=1", job_ready_o); end
    tick(); tick(); tick();
    checks++; if ({ctrl_start_o, busy_o} !== 2'b00) begin failures++; $display("FAIL rej_not_queued got=%b exp=00", {ctrl_start_o, busy_o}); end
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    checks++; if (rejected_o !== 1'b0) begin failures++; $display("FAIL rej_clear got=%0b exp=0", rejected_o); end
    push_job(16'd4, 16'd4, 16'd0, 16'h1, 16'h2, 16'h3);
    checks++; if (rejected_o !== 1'b1) begin failures++; $display("FAIL rej_n0 got=%0b exp=1", rejected_o); end
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    set_job(16'd0, 16'd3, 16'd3, 16'h1, 16'h2, 16'h3);
    job_valid_i = 1'b1; clear_i = 1'b1;
    tick();
    job_valid_i = 1'b0; clear_i = 1'b0;
    checks++; if (rejected_o !== 1'b0) begin failures++; $display("FAIL rej_clear_wins got=%0b exp=0", rejected_o); end
    tick(); tick(); tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rej_m0_busy got=%0b exp=0", busy_o); end
  endtask

  task automatic test_timeout;
    logic [7:0] j0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    push_job(16'd2, 16'd2, 16'd2, 16'h1, 16'h2, 16'h3);
    tick(); tick();
    checks++; if ({ctrl_start_o, timeout_o} !== 2'b10) begin failures++; $display("FAIL to_issue got=%b exp=10", {ctrl_start_o, timeout_o}); end
    repeat (7) tick();
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL to_early got=%0b exp=0", timeout_o); end
    tick();
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL to_set got=%0b exp=1", timeout_o); end
    repeat (5) tick();
    checks++; if ({ctrl_start_o, timeout_o} !== 2'b11) begin failures++; $display("FAIL to_no_abort got=%b exp=11", {ctrl_start_o, timeout_o}); end
    j0 = jobs_done_o;
    finish_job();
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL to_done got=%0b exp=1", done_o); end
    checks++; if (jobs_done_o !== j0 + 8'd1) begin failures++; $display("FAIL to_jobs_done got=%0d exp=%0d", jobs_done_o, j0 + 8'd1); end
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    checks++; if ({timeout_o, jobs_done_o} !== 9'd0) begin failures++; $display("FAIL to_clear got=%b exp=0", {timeout_o, jobs_done_o}); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    push_job(16'd3, 16'd3, 16'd3, 16'h1, 16'h2, 16'h3);
    wait_start(ok);
    finish_job();
    checks++; if (!ok || jobs_done_o !== 8'd1) begin failures++; $display("FAIL rm_pre_job ok=%0b got=%0d exp=1", ok, jobs_done_o); end
    push_job(16'd7, 16'd7, 16'd7, 16'h7, 16'h7, 16'h7);
    tick(); tick();
    push_job(16'd8, 16'd8, 16'd8, 16'h8, 16'h8, 16'h8);
    push_job(16'd9, 16'd9, 16'd9, 16'h9, 16'h9, 16'h9);
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if ({ctrl_start_o, busy_o, done_o} !== 3'b000) begin failures++; $display("FAIL rm_async got=%b exp=000", {ctrl_start_o, busy_o, done_o}); end
    checks++; if (jobs_done_o !== 8'd0) begin failures++; $display("FAIL rm_jobs_done got=%0d exp=0", jobs_done_o); end
    checks++; if (ctrl_word() !== '0) begin failures++; $display("FAIL rm_ctrl got=%h exp=0", ctrl_word()); end
    tick();
    rst_i = 1'b0;
    repeat (6) tick();
    checks++; if ({ctrl_start_o, busy_o} !== 2'b00) begin failures++; $display("FAIL rm_no_issue got=%b exp=00", {ctrl_start_o, busy_o}); end
  endtask

  task automatic test_wrap;
    bit ok;
    int d0;
    int missed;
    d0 = done_pulses;
    missed = 0;
    for (int i = 0; i < 256; i++) begin
      push_job(AW'(i + 1), 16'd2, 16'd3, AW'(i), 16'h4, 16'h5);
      wait_start(ok);
      if (!ok) missed++;
      finish_job();
      if (i == 254) begin
        checks++; if (jobs_done_o !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", jobs_done_o); end
      end
    end
    tick();
    checks++; if (missed !== 0) begin failures++; $display("FAIL wrap_issue got_missed=%0d exp=0", missed); end
    checks++; if (jobs_done_o !== 8'd0) begin failures++; $display("FAIL wrap_jobs_done got=%0d exp=0", jobs_done_o); end
    checks++; if (done_pulses - d0 !== 256) begin failures++; $display("FAIL wrap_pulses got=%0d exp=256", done_pulses - d0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
